// File: rtl/ushift_pkg.sv
// ushift_pkg: mode encodings and helpers shared by the universal shift register.
`default_nettype none

package ushift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHL  = 2'b01;
  localparam mode_t MODE_SHR  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ushift_cell.sv
// ushift_cell: one register bit -- 4:1 next-value mux plus async active-low reset flop.
`default_nettype none

module ushift_cell
  import ushift_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  mode_t i_mode,
  input  logic  i_load,
  input  logic  i_shl,
  input  logic  i_shr,
  output logic  o_q,
  output logic  o_qb
);

  logic r_q;
  logic w_nxt;

  always_comb begin
    w_nxt = r_q;
    if (i_en) begin
      case (i_mode)
        MODE_SHL:  w_nxt = i_shl;
        MODE_SHR:  w_nxt = i_shr;
        MODE_LOAD: w_nxt = i_load;
        default:   w_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RST_BIT;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign o_q  = r_q;
  assign o_qb = ~r_q;

endmodule

`default_nettype wire

// File: rtl/ushift_reg.sv
// ushift_reg: universal shift register with saturating shift counter and flush pulse.
// Defining USHIFT_ROTATE_EN turns SHL/SHR into rotates and ignores sin_l/sin_r.
`default_nettype none

module ushift_reg
  import ushift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             flushed
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_shl_in;
  logic [WIDTH-1:0] w_shr_in;

  logic [CNT_W-1:0] r_cnt;
  logic             r_flushed;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_flushed_nxt;

`ifdef USHIFT_ROTATE_EN
  logic w_unused_sin;
  assign w_unused_sin = sin_l ^ sin_r;
  assign w_shl_in     = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
  assign w_shr_in     = {w_q[0], w_q[WIDTH-1:1]};
`else
  assign w_shl_in     = {w_q[WIDTH-2:0], sin_l};
  assign w_shr_in     = {sin_r, w_q[WIDTH-1:1]};
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ushift_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .i_en   (en),
      .i_mode (mode),
      .i_load (d[i]),
      .i_shl  (w_shl_in[i]),
      .i_shr  (w_shr_in[i]),
      .o_q    (w_q[i]),
      .o_qb   (w_qb[i])
    );
  end

  // flushed is a single-edge pulse, so every non-saturating path clears it.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_flushed_nxt = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD) begin
        w_cnt_nxt = '0;
      end else if (is_shift(mode) && (r_cnt != c_CNT_MAX)) begin
        w_cnt_nxt     = r_cnt + 1'b1;
        w_flushed_nxt = (r_cnt == c_CNT_MAX - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_flushed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_flushed <= w_flushed_nxt;
    end
  end

  assign q         = w_q;
  assign qb        = w_qb;
  assign sout_l    = w_q[WIDTH-1];
  assign sout_r    = w_q[0];
  assign shift_cnt = r_cnt;
  assign flushed   = r_flushed;

endmodule

`default_nettype wire

// File: tb/tb_ushift_reg.sv
// tb_ushift_reg: directed and pseudo-random checks of ushift_reg against a behavioural model.
`default_nettype none

module tb_ushift_reg;

  localparam int         W    = 8;
  localparam logic [7:0] RSTV = 8'hA5;
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHL  = 2'b01;
  localparam logic [1:0] SHR  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic [7:0] qb;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] shift_cnt;
  logic       flushed;

  int n_vec = 0;
  int n_err = 0;
  bit check_on = 1'b0;

  ushift_reg #(
    .WIDTH   (W),
    .RST_VAL (RSTV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .qb        (qb),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
    .flushed   (flushed)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer register value, counter saturating at W.
  int m_q   = 0;
  int m_cnt = 0;
  bit m_fl  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   = int'(RSTV);
      m_cnt = 0;
      m_fl  = 1'b0;
    end else begin
      m_fl = 1'b0;
      if (en) begin
        if (mode == LOAD) begin
          m_q   = int'(d);
          m_cnt = 0;
        end else if (mode == SHL || mode == SHR) begin
`ifdef USHIFT_ROTATE_EN
          if (mode == SHL) m_q = ((m_q * 2) + (m_q / 128)) % 256;
          else             m_q = (m_q / 2) + (m_q % 2) * 128;
`else
          if (mode == SHL) m_q = ((m_q * 2) + int'(sin_l)) % 256;
          else             m_q = (m_q / 2) + int'(sin_r) * 128;
`endif
          if (m_cnt < W) begin
            m_cnt = m_cnt + 1;
            m_fl  = (m_cnt == W);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_on) begin
      n_vec++;
      if (int'(q) != m_q) begin
        n_err++; $display("FAIL model q: got %02h want %02h", q, m_q[7:0]);
      end
      if (int'(qb) != (255 - m_q)) begin
        n_err++; $display("FAIL model qb: got %02h want %02h", qb, 8'(255 - m_q));
      end
      if (sout_l != m_q[7] || sout_r != m_q[0]) begin
        n_err++; $display("FAIL model sout: got l=%0b r=%0b want l=%0b r=%0b", sout_l, sout_r, m_q[7], m_q[0]);
      end
      if (int'(shift_cnt) != m_cnt) begin
        n_err++; $display("FAIL model shift_cnt: got %0d want %0d", shift_cnt, m_cnt);
      end
      if (flushed != m_fl) begin
        n_err++; $display("FAIL model flushed: got %0b want %0b", flushed, m_fl);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] dv,
                       input logic l, input logic r);
    @(negedge clk);
    #1;
    en = e; mode = m; d = dv; sin_l = l; sin_r = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic e, input logic [1:0] m, input logic [7:0] dv,
                    input logic l, input logic r);
    drive(e, m, dv, l, r);
    settle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = HOLD; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_lit("reset q", 32'(q), 32'h A5);
    check_lit("reset qb", 32'(qb), 32'h5A);
    check_lit("reset shift_cnt", 32'(shift_cnt), 0);
    check_lit("reset flushed", 32'(flushed), 0);
    check_lit("reset sout_l/r", 32'({sout_l, sout_r}), 32'b11);
    #9 rst = 1'b1;
    check_on = 1'b1;

    op(1, LOAD, 8'h81, 0, 0);
    check_lit("load q", 32'(q), 32'h81);
    op(1, SHL, 8'h00, 0, 0);
`ifdef USHIFT_ROTATE_EN
    check_lit("shl q", 32'(q), 32'h03);
`else
    check_lit("shl q", 32'(q), 32'h02);
`endif
    check_lit("shl sout_l", 32'(sout_l), 0);
    check_lit("shl shift_cnt", 32'(shift_cnt), 1);
    op(1, SHR, 8'h00, 0, 1);
    check_lit("shr q", 32'(q), 32'h81);
    check_lit("shr shift_cnt", 32'(shift_cnt), 2);

    op(1, LOAD, 8'hFF, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      op(1, SHL, 8'h00, 0, 0);
      check_lit($sformatf("flush cnt k=%0d", k), 32'(shift_cnt), (k >= 8) ? 8 : k);
      check_lit($sformatf("flush pulse k=%0d", k), 32'(flushed), (k == 8) ? 1 : 0);
    end
`ifdef USHIFT_ROTATE_EN
    check_lit("flush q", 32'(q), 32'hFF);
`else
    check_lit("flush q", 32'(q), 32'h00);
`endif

    op(1, LOAD, 8'h3C, 0, 0);
    for (int k = 0; k < 7; k++) op(1, SHL, 8'h00, 0, 0);
    check_lit("prio pre cnt", 32'(shift_cnt), 7);
    op(1, LOAD, 8'h3C, 0, 0);
    check_lit("prio q", 32'(q), 32'h3C);
    check_lit("prio cnt", 32'(shift_cnt), 0);
    check_lit("prio flushed", 32'(flushed), 0);

    for (int k = 0; k < 8; k++) op(1, (k % 2 == 0) ? SHL : SHR, 8'h00, 1, 0);
    check_lit("mixed cnt", 32'(shift_cnt), 8);
    check_lit("mixed flushed", 32'(flushed), 1);
    op(0, SHL, 8'h00, 0, 0);
    check_lit("en0 clears flushed", 32'(flushed), 0);
    check_lit("en0 keeps cnt", 32'(shift_cnt), 8);

    op(1, LOAD, 8'h96, 0, 0);
    op(1, SHL, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      op(0, SHL, 8'h00, 1, 1);
`ifdef USHIFT_ROTATE_EN
      check_lit("en0 q", 32'(q), 32'h2D);
`else
      check_lit("en0 q", 32'(q), 32'h2C);
`endif
      check_lit("en0 cnt", 32'(shift_cnt), 1);
    end
    op(1, HOLD, 8'hFF, 1, 1);
    check_lit("hold cnt", 32'(shift_cnt), 1);

    op(1, LOAD, 8'h58, 0, 0);
    op(1, SHL, 8'h00, 0, 0);
    #1 rst = 1'b0;
    #1;
    check_lit("async rst q", 32'(q), 32'hA5);
    check_lit("async rst qb", 32'(qb), 32'h5A);
    check_lit("async rst cnt", 32'(shift_cnt), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    settle();
`ifdef USHIFT_ROTATE_EN
    check_lit("post rst shl q", 32'(q), 32'h4B);
`else
    check_lit("post rst shl q", 32'(q), 32'h4A);
`endif
    check_lit("post rst cnt", 32'(shift_cnt), 1);

    op(1, LOAD, 8'h81, 0, 0);
    op(1, SHL, 8'h00, 0, 1);
`ifdef USHIFT_ROTATE_EN
    check_lit("seq shl", 32'(q), 32'h03);
    op(1, SHR, 8'h00, 1, 0);
    check_lit("seq shr1", 32'(q), 32'h81);
    op(1, SHR, 8'h00, 0, 1);
    check_lit("seq shr2", 32'(q), 32'hC0);
`else
    check_lit("seq shl", 32'(q), 32'h02);
    op(1, SHR, 8'h00, 1, 0);
    check_lit("seq shr1", 32'(q), 32'h01);
    op(1, SHR, 8'h00, 0, 1);
    check_lit("seq shr2", 32'(q), 32'h80);
`endif

    for (int k = 0; k < 80; k++) begin
      op(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
         1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1 check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
